ldbr_ctrl: RTL and testbench

//  Load controller for the bias register bank; sits directly upstream of biasregb.

---
 rtl/ldbr_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ldbr_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldbr_ctrl.sv
// Bias-register load controller: accepts a load command, issues one DDR burst
// read, and turns each returned beat into a registered write into the bias bank.
module ldbr_ctrl #(
    parameter int unsigned BR_IND_WTH  = 1,
    parameter int unsigned BR_ADDR_WTH = 9,
    parameter int unsigned BR_DATA_WTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // Load command
    input  logic                   cmd_ldbr__vld_i,
    output logic                   cmd_ldbr__rdy_o,
    input  logic [BR_IND_WTH-1:0]  cmd_ldbr__index_i,
    input  logic [BR_ADDR_WTH-1:0] cmd_ldbr__waddr_i,
    input  logic [BR_ADDR_WTH:0]   cmd_ldbr__len_i,
    // DDR burst read request
    output logic                   ldbr_ddr__req_o,
    output logic [BR_ADDR_WTH:0]   ldbr_ddr__len_o,
    input  logic                   ldbr_ddr__ack_i,
    // DDR returned beats
    input  logic [BR_DATA_WTH-1:0] ddr_ldbr__rdata_i,
    input  logic                   ddr_ldbr__rdata_act_i,
    // Bias bank write port
    output logic [BR_IND_WTH-1:0]  ldmr_brb__windex_o,
    output logic [BR_ADDR_WTH-1:0] ldmr_brb__waddr_o,
    output logic                   ldmr_brb__we_o,
    output logic [BR_DATA_WTH-1:0] ldmr_brb__wdata_o,
    output logic                   ldmr_brb__wdata_act_o,
    // Status back to the issuing controller
    output logic                   ldbr_cmd__done_o,
    output logic                   ldbr_cmd__err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

    localparam logic [BR_ADDR_WTH-1:0] AddrOne = {{(BR_ADDR_WTH - 1){1'b0}}, 1'b1};
    localparam logic [BR_ADDR_WTH:0]   CntOne  = {{BR_ADDR_WTH{1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [BR_IND_WTH-1:0]    index_q;
    logic [BR_ADDR_WTH-1:0]   addr_q;
    logic [BR_ADDR_WTH:0]     len_q;
    logic [BR_ADDR_WTH:0]     cnt_q;
    logic [BR_ADDR_WTH:0]     cnt_inc;
    logic [BR_IND_WTH-1:0]    windex_q;
    logic [BR_ADDR_WTH-1:0]   waddr_q;
    logic [BR_DATA_WTH-1:0]   wdata_q;
    logic                     we_q;
    logic                     done_q;
    logic                     err_q;
    logic                     accept;
    logic                     beat_ok;
    logic                     last_beat;

    // Command handshake and beat qualification
    always_comb begin
        accept    = cmd_ldbr__vld_i && (state_q == StIdle);
        beat_ok   = ddr_ldbr__rdata_act_i && (state_q == StData);
        cnt_inc   = cnt_q + CntOne;
        // cnt_q never exceeds len-1 in DATA, so cnt_inc cannot overflow
        last_beat = beat_ok && (cnt_inc == len_q);
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_ldbr__vld_i) begin
                    // Zero-length loads skip the DDR request entirely
                    state_d = (cmd_ldbr__len_i == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                if (ldbr_ddr__ack_i) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (last_beat) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from current state
    always_comb begin
        cmd_ldbr__rdy_o = (state_q == StIdle);
        ldbr_ddr__req_o = (state_q == StReq);
    end

    // Command latch, running address and beat counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            index_q <= cmd_ldbr__index_i;
            addr_q  <= cmd_ldbr__waddr_i;
            len_q   <= cmd_ldbr__len_i;
            cnt_q   <= '0;
        end else if (beat_ok) begin
            // Address wraps naturally at the bank depth
            addr_q  <= addr_q + AddrOne;
            cnt_q   <= cnt_inc;
        end
    end

    // Registered bank write; index/addr/data hold between writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            windex_q <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= beat_ok;
            if (beat_ok) begin
                windex_q <= index_q;
                waddr_q  <= addr_q;
                wdata_q  <= ddr_ldbr__rdata_i;
            end
        end
    end

    // Completion pulse and sticky stray-beat error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            err_q  <= err_q | (ddr_ldbr__rdata_act_i && (state_q != StData));
        end
    end

    assign ldbr_ddr__len_o       = len_q;
    assign ldmr_brb__windex_o    = windex_q;
    assign ldmr_brb__waddr_o     = waddr_q;
    assign ldmr_brb__we_o        = we_q;
    assign ldmr_brb__wdata_o     = wdata_q;
    assign ldmr_brb__wdata_act_o = we_q;
    assign ldbr_cmd__done_o      = done_q;
    assign ldbr_cmd__err_o       = err_q;

endmodule

// File: tb/tb_ldbr_ctrl.sv
// Randomized bench for ldbr_ctrl with a queue-based write-stream reference model.
module tb_ldbr_ctrl;

    localparam int IW = 1;
    localparam int AW = 9;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [IW-1:0] cmd_index;
    logic [AW-1:0] cmd_waddr;
    logic [AW:0]   cmd_len;
    logic          req;
    logic [AW:0]   ddr_len;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          rdata_act;
    logic [IW-1:0] windex;
    logic [AW-1:0] waddr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          wdata_act;
    logic          done;
    logic          err;

    ldbr_ctrl #(
        .BR_IND_WTH (IW),
        .BR_ADDR_WTH(AW),
        .BR_DATA_WTH(DW)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .cmd_ldbr__vld_i      (cmd_vld),
        .cmd_ldbr__rdy_o      (cmd_rdy),
        .cmd_ldbr__index_i    (cmd_index),
        .cmd_ldbr__waddr_i    (cmd_waddr),
        .cmd_ldbr__len_i      (cmd_len),
        .ldbr_ddr__req_o      (req),
        .ldbr_ddr__len_o      (ddr_len),
        .ldbr_ddr__ack_i      (ack),
        .ddr_ldbr__rdata_i    (rdata),
        .ddr_ldbr__rdata_act_i(rdata_act),
        .ldmr_brb__windex_o   (windex),
        .ldmr_brb__waddr_o    (waddr),
        .ldmr_brb__we_o       (we),
        .ldmr_brb__wdata_o    (wdata),
        .ldmr_brb__wdata_act_o(wdata_act),
        .ldbr_cmd__done_o     (done),
        .ldbr_cmd__err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    wr_t         mon_w;
    int          done_seen = 0;
    bit          exp_err   = 1'b0;
    int unsigned n_chk     = 0;
    int unsigned n_err     = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Passive monitor: collects bank writes and done pulses on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("act_eq_we", wdata_act, we);
            if (we) begin
                mon_w.idx  = windex;
                mon_w.addr = waddr;
                mon_w.data = wdata;
                obs_q.push_back(mon_w);
            end
            if (done) done_seen++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst     = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_rdy", cmd_rdy, 1);
        chk("rst_req", req, 0);
        chk("rst_len", ddr_len, 0);
        chk("rst_we", we, 0);
        chk("rst_act", wdata_act, 0);
        chk("rst_windex", windex, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (!cmd_rdy && t < 50) begin
            cyc();
            t++;
        end
        chk("rdy_wait", cmd_rdy, 1);
    endtask

    task automatic compare_writes();
        int n;
        chk("n_writes", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("write", obs_q[i], exp_q[i]);
    endtask

    // One complete load: command, request/ack, beats, completion and checks
    task automatic run_load(input logic [IW-1:0] idx, input logic [AW-1:0] wa, input int len,
                            input int ack_dly, input int gap_min, input int gap_max,
                            input bit pre_beat, input int extra);
        int            d0;
        int            gaps;
        wr_t           w;
        logic [AW-1:0] a;
        obs_q.delete();
        exp_q.delete();
        wait_rdy();
        d0        = done_seen;
        cmd_vld   = 1'b1;
        cmd_index = idx;
        cmd_waddr = wa;
        cmd_len   = len[AW:0];
        cyc();
        cmd_vld   = 1'b0;
        cmd_index = IW'($urandom);
        cmd_waddr = AW'($urandom);
        cmd_len   = (AW + 1)'($urandom);
        chk("rdy_busy", cmd_rdy, 0);
        if (len == 0) begin
            chk("req_len0", req, 0);
            chk("done_early0", done, 0);
            cyc();
            chk("done_len0", done, 1);
            chk("req_len0b", req, 0);
            chk("rdy_back0", cmd_rdy, 1);
            cyc();
            chk("done_one_shot0", done, 0);
        end else begin
            chk("req_on", req, 1);
            chk("ddr_len", ddr_len, len);
            for (int i = 0; i < ack_dly; i++) begin
                if (pre_beat && i == 0) begin
                    rdata_act = 1'b1;
                    rdata     = {$urandom, $urandom};
                    exp_err   = 1'b1;
                end
                cyc();
                rdata_act = 1'b0;
                chk("req_hold", req, 1);
                chk("len_hold", ddr_len, len);
            end
            ack = 1'b1;
            cyc();
            ack = 1'b0;
            chk("req_drop", req, 0);
            for (int i = 0; i < len; i++) begin
                gaps = $urandom_range(gap_max, gap_min);
                for (int g = 0; g < gaps; g++) begin
                    rdata     = {$urandom, $urandom};
                    ack       = 1'($urandom);
                    cmd_vld   = 1'($urandom);
                    cmd_waddr = AW'($urandom);
                    cmd_len   = (AW + 1)'($urandom);
                    cyc();
                    chk("we_gap", we, 0);
                end
                cmd_vld   = 1'b0;
                ack       = 1'b0;
                rdata_act = 1'b1;
                rdata     = {$urandom, $urandom};
                a         = wa + AW'(i);
                w.idx     = idx;
                w.addr    = a;
                w.data    = rdata;
                exp_q.push_back(w);
                cyc();
                rdata_act = 1'b0;
                chk("we_lat", we, 1);
                chk("waddr_now", waddr, a);
            end
            chk("done_early", done, 0);
            cyc();
            chk("done_pulse", done, 1);
            chk("rdy_back", cmd_rdy, 1);
            chk("we_after", we, 0);
            for (int e = 0; e < extra; e++) begin
                rdata_act = 1'b1;
                rdata     = {$urandom, $urandom};
                exp_err   = 1'b1;
                cyc();
                rdata_act = 1'b0;
                chk("no_write_extra", we, 0);
            end
        end
        cyc();
        chk("done_once", done_seen - d0, 1);
        compare_writes();
        chk("err_flag", err, exp_err);
    endtask

    initial begin
        int            ln;
        int            ad;
        bit            pb;
        logic [DW-1:0] d;
        rst       = 1'b1;
        cmd_vld   = 1'b0;
        cmd_index = '0;
        cmd_waddr = '0;
        cmd_len   = '0;
        ack       = 1'b0;
        rdata     = '0;
        rdata_act = 1'b0;
        cyc();
        cyc();
        chk_reset_vals();
        rst = 1'b0;
        cyc();

        // Basic load, back-to-back beats
        run_load(1'b1, 9'h010, 4, 2, 0, 0, 1'b0, 0);
        // Address wrap with gaps
        run_load(1'b0, 9'h1FE, 4, 1, 1, 3, 1'b0, 0);
        // Zero-length load
        run_load(1'b1, 9'h055, 0, 0, 0, 0, 1'b0, 0);
        // Full-depth load followed by a stray beat
        run_load(1'b0, 9'h000, 512, 0, 0, 0, 1'b0, 1);

        // Stray beat while the request is pending
        do_reset();
        chk("err_cleared", err, 0);
        run_load(1'b1, 9'h100, 5, 3, 0, 2, 1'b1, 0);

        // Reset in the middle of a load
        do_reset();
        obs_q.delete();
        wait_rdy();
        cmd_vld   = 1'b1;
        cmd_index = 1'b1;
        cmd_waddr = 9'h020;
        cmd_len   = 10'd8;
        cyc();
        cmd_vld = 1'b0;
        ack     = 1'b1;
        cyc();
        ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rdata_act = 1'b1;
            d         = {$urandom, $urandom};
            rdata     = d;
            cyc();
        end
        rdata_act = 1'b0;
        cyc();
        chk("mid_writes", obs_q.size(), 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_reset_vals();
        for (int i = 0; i < 3; i++) begin
            rdata_act = 1'b1;
            rdata     = {$urandom, $urandom};
            cyc();
        end
        rdata_act = 1'b0;
        cyc();
        chk("post_rst_writes", obs_q.size(), 2);
        chk("post_rst_err", err, 1);
        do_reset();
        chk("err_cleared2", err, 0);
        run_load(1'b0, 9'h0F0, 6, 1, 0, 1, 1'b0, 0);

        // Randomized loads
        for (int r = 0; r < 20; r++) begin
            ln = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(40, 1));
            ad = $urandom_range(4, 0);
            pb = (ad > 0) && ($urandom_range(3, 0) == 0);
            run_load(IW'($urandom), AW'($urandom), ln, ad, 0, $urandom_range(3, 0), pb,
                     $urandom_range(1, 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
